bcd_timer_ctrl: RTL and testbench
=================================

# bcd_timer_ctrl

Run/hold/countdown controller for the 4-digit BCD counter that feeds the seven-segment display multiplexer. It is clocked by the 1 Hz tick S_clk. It sequences up-count, down-count, pause, preload and terminal-count alarm. It presents four BCD digits plus a per-digit blank mask to the refresh/decode logic downstream.

## Interface
- ALARM_CYCLES, default 5: number of S_clk cycles spent in DONE before returning to IDLE (range 1–15).
- S_clk  in  1  1 Hz tick clock; all state changes occur on its rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_start  in  1  enter/resume RUN; level, sampled each edge.
- cmd_stop  in  1  pause RUN into HOLD.
- cmd_clear  in  1  force digits to 0000 and state to IDLE.
- dir  in  1  0 = up, 1 = down; sampled on every transition into RUN.
- load_en  in  1  preload digits from load_bcd (IDLE/HOLD only).
- load_bcd  in  16  preload value {d4,d3,d2,d1}, one BCD nibble per digit.
- digits  out  16  current count {d4,d3,d2,d1}.
- blank  out  4  per-digit blank, 1 = blanked; bit0 = d1.
- running  out  1  1 while in RUN.
- alarm  out  1  1 while in DONE.
- state_o  out  2  IDLE=0, RUN=1, HOLD=2, DONE=3.

## Operation
- Command priority on any edge: cmd_clear > load_en > cmd_stop > cmd_start.
- cmd_clear, any state: digits=0000, state→IDLE, alarm counter=0.
- load_en, IDLE/HOLD: digits←load_bcd. Any nibble >9 saturates to 9. State is unchanged. Ignored in RUN/DONE.
- IDLE:
  - cmd_start with dir=0 → RUN (up).
  - cmd_start with dir=1 and digits≠0000 → RUN (down).
  - cmd_start with dir=1 and digits=0000 → DONE directly, no step.
- RUN: one BCD step per edge in the latched direction.
  - Up: each digit 9→0 carries; 9999→0000 wraps and stays in RUN.
  - Down: each digit 0→9 borrows. The step that produces 0000 also moves state→DONE on the same edge.
  - cmd_stop → HOLD; no step on that edge.
- HOLD: digits frozen. cmd_start → RUN with dir resampled. The down-with-0000 rule is the same as in IDLE.
- DONE: digits frozen at 0000 (or the value held on a direct entry).
  - alarm=1.
  - Internal counter runs 0..ALARM_CYCLES-1, then state→IDLE.
  - cmd_start and cmd_stop are ignored; cmd_clear is honoured.
- blank, combinational from registered state/digits:
  - In DONE: 1111 on even alarm-count values, 0000 on odd (blink, starting blanked).
  - Otherwise: leading-zero suppression. d4 blanked if d4=0; d3 if d4=d3=0; d2 if d4=d3=d2=0; d1 never blanked.
- Reset values: digits=0000, state IDLE, running=0, alarm=0, blank=1110, alarm counter=0, latched dir=0.

## Timing
- Commands are sampled on a rising edge; the resulting digits/state are visible after that same edge (1-cycle latency).
- Upstream holds command levels across at least one S_clk edge; there is no internal edge detection.
- Simultaneous cmd_start and cmd_stop in RUN or HOLD resolves to stop.
- running, alarm and state_o are registered-state decodes with no extra delay.
- reset asserted mid-RUN or mid-DONE forces all reset values immediately, without waiting for an edge. Release is synchronous to the next edge.

## Structure
- Shared display package holds:
  - State encoding constants (IDLE/RUN/HOLD/DONE).
  - BCD_MAX=4'd9, BCD_ZERO=16'h0000.
  - Reset blank mask 4'b1110.
- Sub-module bcd_digit, instantiated 4×: one decade with inc/dec enable, carry/borrow in and out, and synchronous load. The controller chains the four instances and owns the FSM and alarm counter.

## Test plan
- Load 0x0095, start dir=0, 6 edges → 0096,0097,0098,0099,0100,0101. Blank at 0101 = 1000.
- Load 0x9998, start up, 3 edges → 9999,0000,0001. running stays 1 throughout.
- Load 0x0003, start down → 0002,0001,0000. DONE on the 0000 edge with alarm=1. blank 1111,0000,1111,0000,1111 for ALARM_CYCLES=5, then IDLE with alarm=0 and blank=1110.
- Running up from 0010:
  - cmd_start+cmd_stop together → HOLD, digits stay 0010.
  - 3 idle edges → still 0010.
  - cmd_start dir=1 → 0009, direction change takes effect.
- In RUN at 0042, assert cmd_clear+load_en → 0000, IDLE. Separately, in DONE, assert async reset between edges → outputs reach reset values immediately.
- In IDLE, load_bcd=0xA3F0 → digits=9390. Then start dir=1 with digits=0000 after clear → DONE directly, digits unchanged.

Source files
------------

// File: rtl/bcd_timer_ctrl_pkg.sv
// Shared display package for the BCD timer controller.
// Holds the FSM state encoding, BCD constants, the reset blank mask and a
// saturating helper used when preloading digits.
package bcd_timer_ctrl_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned BUS_W       = DIGIT_W * NUM_DIGITS;
  localparam int unsigned ALARM_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [DIGIT_W-1:0]    BCD_MAX   = 4'd9;
  localparam logic [BUS_W-1:0]      BCD_ZERO  = 16'h0000;
  localparam logic [BUS_W-1:0]      BCD_ONE   = 16'h0001;
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = 4'b1110;

  // Clamp every nibble above 9 down to 9.
  function automatic logic [BUS_W-1:0] sat_bcd(input logic [BUS_W-1:0] v);
    logic [BUS_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) r[i*DIGIT_W +: DIGIT_W] = BCD_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_timer_ctrl_digit.sv
// One BCD decade: synchronous load, increment/decrement gated by carry-in,
// carry/borrow-out for chaining.
// Ports:
//   S_clk, reset      clock, async active-high reset (digit -> 0)
//   i_load/i_load_val synchronous load, wins over stepping
//   i_inc/i_dec       step direction enables (i_inc wins if both set)
//   i_cin             step this decade (carry/borrow from lower decade)
//   o_digit           current decade value
//   o_cout            carry (9->0) or borrow (0->9) to next decade
module bcd_digit
  import bcd_timer_ctrl_pkg::*;
(
  input  logic               S_clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [DIGIT_W-1:0] i_load_val,
  input  logic               i_inc,
  input  logic               i_dec,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_cout
);

  logic [DIGIT_W-1:0] r_digit;

  // Decade register with wrap at 9/0.
  always_ff @(posedge S_clk or posedge reset) begin
    if (reset) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_cin) begin
      if (i_inc) begin
        r_digit <= (r_digit == BCD_MAX) ? '0 : r_digit + DIGIT_W'(1);
      end else if (i_dec) begin
        r_digit <= (r_digit == '0) ? BCD_MAX : r_digit - DIGIT_W'(1);
      end
    end
  end

  assign o_digit = r_digit;
  assign o_cout  = i_cin & ((i_inc & (r_digit == BCD_MAX)) |
                            (~i_inc & i_dec & (r_digit == '0)));

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Run/hold/countdown controller for the 4-digit BCD display counter.
// Ports:
//   S_clk, reset     1 Hz tick clock, async active-high reset
//   i_cmd_start      enter/resume RUN (level)
//   i_cmd_stop       pause RUN into HOLD
//   i_cmd_clear      digits -> 0000, state -> IDLE
//   i_dir            0 = up, 1 = down; latched on entry to RUN
//   i_load_en        preload from i_load_bcd in IDLE/HOLD
//   i_load_bcd       preload value {d4,d3,d2,d1}, nibbles >9 saturate
//   o_digits         current count {d4,d3,d2,d1}
//   o_blank          per-digit blank (bit0 = d1), blink in DONE
//   o_running        1 in RUN
//   o_alarm          1 in DONE
//   o_state          IDLE=0, RUN=1, HOLD=2, DONE=3
module bcd_timer_ctrl
  import bcd_timer_ctrl_pkg::*;
#(
  parameter int unsigned ALARM_CYCLES = 5
) (
  input  logic                  S_clk,
  input  logic                  reset,
  input  logic                  i_cmd_start,
  input  logic                  i_cmd_stop,
  input  logic                  i_cmd_clear,
  input  logic                  i_dir,
  input  logic                  i_load_en,
  input  logic [BUS_W-1:0]      i_load_bcd,
  output logic [BUS_W-1:0]      o_digits,
  output logic [NUM_DIGITS-1:0] o_blank,
  output logic                  o_running,
  output logic                  o_alarm,
  output logic [1:0]            o_state
);

  localparam logic [ALARM_CNT_W-1:0] ALARM_LAST = ALARM_CNT_W'(ALARM_CYCLES - 1);

  state_e                 r_state, w_state_nxt;
  logic                   r_dir, w_dir_nxt;
  logic [ALARM_CNT_W-1:0] r_alarm_cnt, w_alarm_cnt_nxt;
  logic                   w_load, w_inc, w_dec;
  logic [BUS_W-1:0]       w_load_val;
  logic [BUS_W-1:0]       w_digits;
  logic [NUM_DIGITS:0]    w_carry;
  logic                   w_unused_wrap;

  // Decade chain: lowest digit always steps when enabled, others on carry.
  assign w_carry[0] = 1'b1;
  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_digit
    bcd_digit u_digit (
      .S_clk      (S_clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val[g*DIGIT_W +: DIGIT_W]),
      .i_inc      (w_inc),
      .i_dec      (w_dec),
      .i_cin      (w_carry[g]),
      .o_digit    (w_digits[g*DIGIT_W +: DIGIT_W]),
      .o_cout     (w_carry[g+1])
    );
  end
  // Up-count wrap out of d4 is legal and needs no action.
  assign w_unused_wrap = w_carry[NUM_DIGITS];

  // State, latched direction and alarm counter.
  always_ff @(posedge S_clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dir       <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_alarm_cnt <= w_alarm_cnt_nxt;
    end
  end

  // Next state and digit-chain controls; clear > load > stop > start.
  always_comb begin
    w_state_nxt     = r_state;
    w_dir_nxt       = r_dir;
    w_alarm_cnt_nxt = r_alarm_cnt;
    w_load          = 1'b0;
    w_load_val      = BCD_ZERO;
    w_inc           = 1'b0;
    w_dec           = 1'b0;

    if (i_cmd_clear) begin
      w_state_nxt     = ST_IDLE;
      w_alarm_cnt_nxt = '0;
      w_load          = 1'b1;
      w_load_val      = BCD_ZERO;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (i_load_en) begin
            w_load     = 1'b1;
            w_load_val = sat_bcd(i_load_bcd);
          end else if (i_cmd_stop) begin
            w_state_nxt = r_state;
          end else if (i_cmd_start) begin
            // Counting down from zero has nothing to do: alarm at once.
            if (i_dir && (w_digits == BCD_ZERO)) begin
              w_state_nxt     = ST_DONE;
              w_alarm_cnt_nxt = '0;
            end else begin
              w_state_nxt = ST_RUN;
              w_dir_nxt   = i_dir;
            end
          end
        end
        ST_RUN: begin
          if (i_cmd_stop) begin
            w_state_nxt = ST_HOLD;
          end else if (r_dir) begin
            w_dec = 1'b1;
            // The only value whose down-step yields 0000.
            if (w_digits == BCD_ONE) begin
              w_state_nxt     = ST_DONE;
              w_alarm_cnt_nxt = '0;
            end
          end else begin
            w_inc = 1'b1;
          end
        end
        ST_DONE: begin
          if (r_alarm_cnt == ALARM_LAST) begin
            w_state_nxt     = ST_IDLE;
            w_alarm_cnt_nxt = '0;
          end else begin
            w_alarm_cnt_nxt = r_alarm_cnt + ALARM_CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from registered state and digits.
  always_comb begin
    o_running = 1'b0;
    o_alarm   = 1'b0;
    o_blank   = BLANK_RST;
    unique case (r_state)
      ST_RUN: begin
        o_running = 1'b1;
        o_blank   = {w_digits[15:12] == '0, w_digits[15:8] == '0,
                     w_digits[15:4] == '0, 1'b0};
      end
      ST_DONE: begin
        o_alarm = 1'b1;
        // Blink: blanked on even counts, shown on odd.
        o_blank = r_alarm_cnt[0] ? 4'b0000 : 4'b1111;
      end
      default: begin
        o_blank = {w_digits[15:12] == '0, w_digits[15:8] == '0,
                   w_digits[15:4] == '0, 1'b0};
      end
    endcase
  end

  assign o_digits = w_digits;
  assign o_state  = r_state;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl: expected outputs are queued as each
// cycle's stimulus is driven and compared after the following clock edge.
module tb_bcd_timer_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        S_clk;
  logic        reset;
  logic        cmd_start, cmd_stop, cmd_clear, dir, load_en;
  logic [15:0] load_bcd;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        running, alarm;
  logic [1:0]  state_o;

  typedef struct {
    logic [15:0] dig;
    logic [1:0]  st;
    logic [3:0]  blk;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [15:0] seq_up[6];

  bcd_timer_ctrl #(.ALARM_CYCLES(5)) dut (
    .S_clk       (S_clk),
    .reset       (reset),
    .i_cmd_start (cmd_start),
    .i_cmd_stop  (cmd_stop),
    .i_cmd_clear (cmd_clear),
    .i_dir       (dir),
    .i_load_en   (load_en),
    .i_load_bcd  (load_bcd),
    .o_digits    (digits),
    .o_blank     (blank),
    .o_running   (running),
    .o_alarm     (alarm),
    .o_state     (state_o)
  );

  initial S_clk = 1'b0;
  always #5 S_clk = ~S_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Leading-zero suppression mask expected outside DONE.
  function automatic logic [3:0] lz(input logic [15:0] d);
    lz = {d[15:12] == 4'd0, d[15:8] == 8'd0, d[15:4] == 12'd0, 1'b0};
  endfunction

  task automatic push(input logic [15:0] e_dig, input logic [1:0] e_st, input logic [3:0] e_blink);
    exp_t e;
    e.dig = e_dig;
    e.st  = e_st;
    e.blk = (e_st == S_DONE) ? e_blink : lz(e_dig);
    sb.push_back(e);
  endtask

  task automatic score(input string tag);
    exp_t e;
    chk({tag, ".sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".dig"},   32'(digits),  32'(e.dig));
      chk({tag, ".state"}, 32'(state_o), 32'(e.st));
      chk({tag, ".blank"}, 32'(blank),   32'(e.blk));
      chk({tag, ".run"},   32'(running), 32'(e.st == S_RUN));
      chk({tag, ".alarm"}, 32'(alarm),   32'(e.st == S_DONE));
    end
  endtask

  // Drive one cycle of commands, then score the post-edge outputs.
  task automatic cyc(input string tag, input logic st, input logic sp, input logic cl,
                     input logic ld, input logic dr, input logic [15:0] lb,
                     input logic [15:0] e_dig, input logic [1:0] e_st, input logic [3:0] e_blink);
    cmd_start = st;
    cmd_stop  = sp;
    cmd_clear = cl;
    load_en   = ld;
    dir       = dr;
    load_bcd  = lb;
    push(e_dig, e_st, e_blink);
    @(posedge S_clk);
    #1;
    score(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    cmd_start = 0; cmd_stop = 0; cmd_clear = 0; dir = 0; load_en = 0; load_bcd = '0;
    seq_up = '{16'h0096, 16'h0097, 16'h0098, 16'h0099, 16'h0100, 16'h0101};

    @(posedge S_clk); #1;
    push(16'h0000, S_IDLE, 4'b0000);
    score("reset");
    chk("reset.blank1110", 32'(blank), 32'h0000_000e);
    @(negedge S_clk);
    reset = 1'b0;

    // Up count across decade carries.
    cyc("t1_load",  0,0,0,1,0,16'h0095, 16'h0095, S_IDLE, 4'h0);
    cyc("t1_start", 1,0,0,0,0,16'h0000, 16'h0095, S_RUN,  4'h0);
    for (int i = 0; i < 6; i++) cyc("t1_up", 0,0,0,0,0,16'h0000, seq_up[i], S_RUN, 4'h0);
    chk("t1_blank0101", 32'(blank), 32'h0000_0008);
    cyc("t1_stop",  0,1,0,0,0,16'h0000, 16'h0101, S_HOLD, 4'h0);
    cyc("t1_clr",   0,0,1,0,0,16'h0000, 16'h0000, S_IDLE, 4'h0);

    // 9999 wraps to 0000 and keeps running.
    cyc("t2_load",  0,0,0,1,0,16'h9998, 16'h9998, S_IDLE, 4'h0);
    cyc("t2_start", 1,0,0,0,0,16'h0000, 16'h9998, S_RUN,  4'h0);
    cyc("t2_9999",  0,0,0,0,0,16'h0000, 16'h9999, S_RUN,  4'h0);
    cyc("t2_wrap",  0,0,0,0,0,16'h0000, 16'h0000, S_RUN,  4'h0);
    cyc("t2_0001",  0,0,0,0,0,16'h0000, 16'h0001, S_RUN,  4'h0);
    cyc("t2_clr",   0,0,1,0,0,16'h0000, 16'h0000, S_IDLE, 4'h0);

    // Countdown to zero, alarm blink for 5 cycles, start/stop ignored in DONE.
    cyc("t3_load",  0,0,0,1,0,16'h0003, 16'h0003, S_IDLE, 4'h0);
    cyc("t3_start", 1,0,0,0,1,16'h0000, 16'h0003, S_RUN,  4'h0);
    cyc("t3_0002",  0,0,0,0,1,16'h0000, 16'h0002, S_RUN,  4'h0);
    cyc("t3_0001",  0,0,0,0,1,16'h0000, 16'h0001, S_RUN,  4'h0);
    cyc("t3_done0", 0,0,0,0,1,16'h0000, 16'h0000, S_DONE, 4'b1111);
    cyc("t3_done1", 0,0,0,0,0,16'h0000, 16'h0000, S_DONE, 4'b0000);
    cyc("t3_done2", 1,1,0,0,0,16'h0000, 16'h0000, S_DONE, 4'b1111);
    cyc("t3_done3", 1,0,0,0,0,16'h0000, 16'h0000, S_DONE, 4'b0000);
    cyc("t3_done4", 0,0,0,0,0,16'h0000, 16'h0000, S_DONE, 4'b1111);
    cyc("t3_idle",  0,0,0,0,0,16'h0000, 16'h0000, S_IDLE, 4'h0);

    // Start+stop together pauses; resume with a new direction.
    cyc("t4_load",  0,0,0,1,0,16'h0008, 16'h0008, S_IDLE, 4'h0);
    cyc("t4_start", 1,0,0,0,0,16'h0000, 16'h0008, S_RUN,  4'h0);
    cyc("t4_0009",  0,0,0,0,0,16'h0000, 16'h0009, S_RUN,  4'h0);
    cyc("t4_0010",  0,0,0,0,0,16'h0000, 16'h0010, S_RUN,  4'h0);
    cyc("t4_stst",  1,1,0,0,0,16'h0000, 16'h0010, S_HOLD, 4'h0);
    for (int i = 0; i < 3; i++) cyc("t4_hold", 0,0,0,0,0,16'h0000, 16'h0010, S_HOLD, 4'h0);
    cyc("t4_resume",1,0,0,0,1,16'h0000, 16'h0010, S_RUN,  4'h0);
    cyc("t4_0009d", 0,0,0,0,0,16'h0000, 16'h0009, S_RUN,  4'h0);
    cyc("t4_0008d", 0,0,0,0,0,16'h0000, 16'h0008, S_RUN,  4'h0);
    cyc("t4_clr",   0,0,1,0,0,16'h0000, 16'h0000, S_IDLE, 4'h0);

    // Load ignored in RUN; clear beats load.
    cyc("t5_load",  0,0,0,1,0,16'h0042, 16'h0042, S_IDLE, 4'h0);
    cyc("t5_start", 1,0,0,0,0,16'h0000, 16'h0042, S_RUN,  4'h0);
    cyc("t5_ldrun", 0,0,0,1,0,16'h5555, 16'h0043, S_RUN,  4'h0);
    cyc("t5_clrld", 0,0,1,1,0,16'h1234, 16'h0000, S_IDLE, 4'h0);

    // Async reset between edges while in DONE.
    cyc("t6_load",  0,0,0,1,0,16'h0001, 16'h0001, S_IDLE, 4'h0);
    cyc("t6_start", 1,0,0,0,1,16'h0000, 16'h0001, S_RUN,  4'h0);
    cyc("t6_done0", 0,0,0,0,1,16'h0000, 16'h0000, S_DONE, 4'b1111);
    cyc("t6_done1", 0,0,0,0,0,16'h0000, 16'h0000, S_DONE, 4'b0000);
    #2 reset = 1'b1;
    #1;
    push(16'h0000, S_IDLE, 4'h0);
    score("t6_async");
    @(negedge S_clk);
    reset = 1'b0;
    cyc("t6_post",  0,0,0,0,0,16'h0000, 16'h0000, S_IDLE, 4'h0);

    // Saturating load, load beats start, direct DONE from 0000 down.
    cyc("t7_sat",   0,0,0,1,0,16'hA3F0, 16'h9390, S_IDLE, 4'h0);
    cyc("t7_ldst",  1,0,0,1,0,16'h0007, 16'h0007, S_IDLE, 4'h0);
    cyc("t7_clr",   0,0,1,0,0,16'h0000, 16'h0000, S_IDLE, 4'h0);
    cyc("t7_direct",1,0,0,0,1,16'h0000, 16'h0000, S_DONE, 4'b1111);
    cyc("t7_done1", 0,0,0,0,0,16'h0000, 16'h0000, S_DONE, 4'b0000);
    cyc("t7_clrdn", 0,0,1,0,0,16'h0000, 16'h0000, S_IDLE, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
